// File: rtl/sample_feeder.sv
// Sample FIFO feeding a downstream averaging stage: buffers 4-bit samples and
// issues them as registered x/x_load strobes spaced at least GAP idle cycles apart.
module sample_feeder #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       hold,
  output logic [3:0] x,
  output logic       x_load,
  output logic [4:0] count,
  output logic       ovf
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL   = 5'(DEPTH);
  localparam logic [3:0] GAP_LD = 4'(GAP);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    gap_cnt;
  logic          push;
  logic          pop;

  // Handshake and issue decisions use registered state only, so in_ready has
  // no combinational path from in_valid or hold.
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (count != 5'd0) && !hold && (gap_cnt == 4'd0);

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= 5'd0;
      gap_cnt <= 4'd0;
      x       <= 4'd0;
      x_load  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (pop) begin
        x       <= mem[rd_ptr];
        x_load  <= 1'b1;
        rd_ptr  <= rd_ptr + AW'(1);
        gap_cnt <= GAP_LD;
      end else begin
        x_load <= 1'b0;
        // The gap keeps counting down while hold is high.
        if (gap_cnt != 4'd0) begin
          gap_cnt <= gap_cnt - 4'd1;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: three instances (GAP=1, 0, 3) share stimulus and are
// compared every cycle against a queue-based model, plus directed scenarios.
module tb_sample_feeder;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       hold;

  logic       rdy_o [3];
  logic [3:0] x_o   [3];
  logic       xl_o  [3];
  logic [4:0] cnt_o [3];
  logic       ovf_o [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a queue of buffered samples per instance.
  int         mq   [3][$];
  int         mgap [3];
  logic [3:0] mx   [3];
  logic       mxl  [3];
  logic       movf [3];

  // Observed issued samples and the edge index they appeared after.
  int ov [3][$];
  int oc [3][$];

  for (genvar i = 0; i < 3; i++) begin : g_dut
    sample_feeder #(
      .DEPTH(4),
      .GAP  (i == 0 ? 1 : (i == 1 ? 0 : 3))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(rdy_o[i]),
      .hold    (hold),
      .x       (x_o[i]),
      .x_load  (xl_o[i]),
      .count   (cnt_o[i]),
      .ovf     (ovf_o[i])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      ov[i].delete();
      oc[i].delete();
    end
    cyc = -1;
  endtask

  // Drive one cycle, advance the model, then compare all instances.
  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic h);
    rst = r; in_valid = v; in_data = d; hold = h;
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        mq[i].delete();
        mgap[i] = 0; mx[i] = 4'd0; mxl[i] = 1'b0; movf[i] = 1'b0;
      end else begin
        bit rdy;
        bit dp;
        rdy = (mq[i].size() != 4);
        dp  = (mq[i].size() != 0) && !h && (mgap[i] == 0);
        if (v && !rdy) movf[i] = 1'b1;
        if (dp) begin
          mx[i]   = 4'(mq[i].pop_front());
          mxl[i]  = 1'b1;
          mgap[i] = gap_of(i);
        end else begin
          mxl[i] = 1'b0;
          if (mgap[i] > 0) mgap[i]--;
        end
        if (v && rdy) mq[i].push_back(int'(d));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks += 5;
      if (cnt_o[i] !== 5'(mq[i].size())) begin
        errors++;
        $display("FAIL model count inst%0d t=%0t: got %0d want %0d", i, $time, cnt_o[i], mq[i].size());
      end
      if (rdy_o[i] !== (mq[i].size() != 4)) begin
        errors++;
        $display("FAIL model in_ready inst%0d t=%0t: got %b want %b", i, $time, rdy_o[i], mq[i].size() != 4);
      end
      if (xl_o[i] !== mxl[i]) begin
        errors++;
        $display("FAIL model x_load inst%0d t=%0t: got %b want %b", i, $time, xl_o[i], mxl[i]);
      end
      if (x_o[i] !== mx[i]) begin
        errors++;
        $display("FAIL model x inst%0d t=%0t: got %0d want %0d", i, $time, x_o[i], mx[i]);
      end
      if (ovf_o[i] !== movf[i]) begin
        errors++;
        $display("FAIL model ovf inst%0d t=%0t: got %b want %b", i, $time, ovf_o[i], movf[i]);
      end
      if (xl_o[i] === 1'b1) begin
        ov[i].push_back(int'(x_o[i]));
        oc[i].push_back(cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd9, 1'b1);
    step(1'b1, 1'b1, 4'd3, 1'b1);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_o[i] !== 5'd0 || rdy_o[i] !== 1'b1 || x_o[i] !== 4'd0 ||
          xl_o[i] !== 1'b0 || ovf_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got count=%0d rdy=%b x=%0d xl=%b ovf=%b want 0/1/0/0/0",
                 i, cnt_o[i], rdy_o[i], x_o[i], xl_o[i], ovf_o[i]);
      end
    end
  endtask

  task automatic test_gap_order();
    int exp_v [4] = '{5, 7, 4, 8};
    int exp_c [4] = '{1, 3, 5, 7};
    step(1'b0, 1'b0, 4'd0, 1'b0);
    clear_logs();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 4'(exp_v[k]), 1'b0);
    idle(8);
    checks++;
    if (ov[0].size() != 4) begin
      errors++;
      $display("FAIL gap1_pulse_count: got %0d want 4", ov[0].size());
    end
    for (int k = 0; k < 4 && k < ov[0].size(); k++) begin
      checks++;
      if (ov[0][k] != exp_v[k] || oc[0][k] != exp_c[k]) begin
        errors++;
        $display("FAIL gap1_pulse%0d: got x=%0d at edge %0d want x=%0d at edge %0d",
                 k, ov[0][k], oc[0][k], exp_v[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_full_ovf();
    int exp_v [4] = '{5, 7, 4, 8};
    step(1'b0, 1'b0, 4'd0, 1'b0);
    clear_logs();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 4'(exp_v[k]), 1'b1);
    checks++;
    if (cnt_o[0] !== 5'd4 || rdy_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d rdy=%b ovf=%b want 4/0/0", cnt_o[0], rdy_o[0], ovf_o[0]);
    end
    step(1'b1, 1'b1, 4'd15, 1'b1);
    checks++;
    if (cnt_o[0] !== 5'd4 || ovf_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_reject: got count=%0d ovf=%b want 4/1", cnt_o[0], ovf_o[0]);
    end
    idle(12);
    checks++;
    if (ov[0].size() != 4 || ovf_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: got %0d pulses ovf=%b want 4 pulses ovf=1", ov[0].size(), ovf_o[0]);
    end
    for (int k = 0; k < 4 && k < ov[0].size(); k++) begin
      checks++;
      if (ov[0][k] != exp_v[k]) begin
        errors++;
        $display("FAIL full_drain%0d: got %0d want %0d", k, ov[0][k], exp_v[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_v [8] = '{1, 2, 3, 4, 9, 9, 9, 9};
    step(1'b0, 1'b0, 4'd0, 1'b0);
    clear_logs();
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 4'(k), 1'b1);
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, 4'd9, 1'b0);
      checks++;
      if (xl_o[1] !== 1'b1 || (j > 0 && cnt_o[1] !== 5'd3)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got x_load=%b count=%0d want 1 and 3", j, xl_o[1], cnt_o[1]);
      end
    end
    idle(6);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= ov[1].size() || ov[1][k] != exp_v[k]) begin
        errors++;
        $display("FAIL b2b_order%0d: got %0d want %0d", k, (k < ov[1].size()) ? ov[1][k] : -1, exp_v[k]);
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 4'd0, 1'b0);
    clear_logs();
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 4'(k), 1'b0);
    idle(4);
    checks++;
    if (ov[1].size() != 12) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 12", ov[1].size());
    end
    for (int k = 0; k < 12 && k < ov[1].size(); k++) begin
      checks++;
      if (ov[1][k] != k) begin
        errors++;
        $display("FAIL wrap_order%0d: got %0d want %0d", k, ov[1][k], k);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, 4'(k), 1'b1);
    step(1'b1, 1'b1, 4'd6, 1'b0);
    checks++;
    if (cnt_o[2] !== 5'd3 || xl_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got count=%0d x_load=%b want 3/1", cnt_o[2], xl_o[2]);
    end
    clear_logs();
    step(1'b0, 1'b1, 4'd11, 1'b0);
    checks++;
    if (cnt_o[2] !== 5'd0 || x_o[2] !== 4'd0 || xl_o[2] !== 1'b0 ||
        ovf_o[2] !== 1'b0 || rdy_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got count=%0d x=%0d xl=%b ovf=%b rdy=%b want 0/0/0/0/1",
               cnt_o[2], x_o[2], xl_o[2], ovf_o[2], rdy_o[2]);
    end
    idle(1);
    checks++;
    if (xl_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_pulse: got x_load=%b want 0", xl_o[2]);
    end
    step(1'b1, 1'b1, 4'd13, 1'b0);
    idle(4);
    checks++;
    if (ov[2].size() != 1 || ov[2][0] != 13) begin
      errors++;
      $display("FAIL midrst_first: got %0d pulses first=%0d want 1 pulse of 13",
               ov[2].size(), (ov[2].size() > 0) ? ov[2][0] : -1);
    end
  endtask

  task automatic test_hold_gap();
    logic h_seq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    step(1'b0, 1'b0, 4'd0, 1'b0);
    clear_logs();
    for (int k = 0; k < 8; k++) step(1'b1, k < 2, (k == 0) ? 4'd10 : 4'd12, h_seq[k]);
    idle(2);
    checks++;
    if (ov[2].size() != 2 || oc[2][0] != 1 || oc[2][1] != 6 || ov[2][0] != 10 || ov[2][1] != 12) begin
      errors++;
      $display("FAIL hold_gap: got %0d pulses at edges %0d,%0d want 10@1 and 12@6",
               ov[2].size(), (ov[2].size() > 0) ? oc[2][0] : -1, (ov[2].size() > 1) ? oc[2][1] : -1);
    end
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(39) != 0, $urandom_range(2) != 0,
           4'($urandom_range(15)), $urandom_range(3) == 0);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 4'd0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mgap[i] = 0; mx[i] = 4'd0; mxl[i] = 1'b0; movf[i] = 1'b0;
    end
    test_reset();
    test_gap_order();
    test_full_ovf();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_hold_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter DEPTH, default 4, meaning FIFO capacity in 4-bit samples (power of two, 2..16).
REQ-003 Parameter GAP, default 1, meaning minimum idle cycles between consecutive x_load pulses (0..15).
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 Port in_data  input  4  sample offered by the producer.
REQ-007 Port in_valid  input  1  producer asserts when in_data is valid.
REQ-008 Port in_ready  output  1  block can accept a sample this cycle.
REQ-009 Port hold  input  1  when high, suppresses issuing samples downstream.
REQ-010 Port x  output  4  sample presented to the downstream averaging stage.
REQ-011 Port x_load  output  1  one-cycle strobe marking x as a new sample.
REQ-012 Port count  output  5  number of samples currently buffered (0..DEPTH).
REQ-013 Port ovf  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 in_ready SHALL equal (count != DEPTH), derived combinationally from registered state only.
REQ-015 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is written at the write pointer, which then increments modulo DEPTH.
REQ-016 A pop SHALL occur on a rising edge where count!=0, hold=0 and the gap counter is 0; x is loaded with the head sample, x_load is set to 1 and the read pointer increments modulo DEPTH.
REQ-017 On a rising edge with no pop, x_load SHALL be 0 and x SHALL hold its previous value.
REQ-018 x and x_load SHALL be registered; a sample pushed at edge k into an empty buffer with an expired gap counter and hold=0 SHALL appear with x_load=1 after edge k+1 (latency 1 cycle, no write-through at edge k).
REQ-019 On a pop the gap counter SHALL load GAP; otherwise it SHALL decrement by 1 each cycle while nonzero, regardless of hold.
REQ-020 With GAP=0, pops SHALL be issued back-to-back every cycle while count!=0 and hold=0.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push-only SHALL increment count, pop-only SHALL decrement count.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 without losing or duplicating samples; samples leave in arrival order.
REQ-023 count SHALL never exceed DEPTH nor go below 0; in_valid while full SHALL leave buffer contents, pointers and count unchanged.
REQ-024 ovf SHALL be set on any rising edge with in_valid=1 and in_ready=0, and SHALL clear only on reset.
REQ-025 When count becomes DEPTH, in_ready SHALL be 0 in the following cycle; a pop from full SHALL restore in_ready=1 in the next cycle.

Reset
REQ-026 On a rising edge with rst=0: count=0, both pointers=0, gap counter=0, x=4'b0000, x_load=0, ovf=0; in_ready=1 after that edge.
REQ-027 Reset SHALL take priority over push and pop on the same edge; buffered samples are discarded on reset mid-operation, and no x_load pulse occurs on that edge or the next.
REQ-028 Buffer storage contents SHALL NOT require reset.

Verification
REQ-029 Reset then GAP=1, hold=0, push 5,7,4,8 on four consecutive edges -> x_load pulses every second cycle with x=5,7,4,8 in order; first pulse one cycle after first push.
REQ-030 hold=1, push 5,7,4,8,15 (DEPTH=4) -> count=4, in_ready=0, fifth write rejected, ovf=1; release hold -> 5,7,4,8 issued, 15 never issued.
REQ-031 GAP=0, buffer full with 1,2,3,4, hold=0, continuous pushes of 9 -> x_load high every cycle, count stays constant once simultaneous push/pop begins, order 1,2,3,4,9,...
REQ-032 Push/pop across 3*DEPTH samples 0..11 with GAP=0 -> output sequence exactly 0..11 (pointer wrap-around).
REQ-033 rst=0 asserted while count=3 and gap counter nonzero -> after edge count=0, x=0, x_load=0, ovf=0; next sample pushed is the first issued.
REQ-034 hold toggled high during gap countdown with GAP=3 -> gap counter still expires; pop occurs on first edge with hold=0 after expiry.
